wb_arbiter: RTL and testbench

// Write-back arbiter in front of regfile: merges the in-order pipeline result (ALU/load, no back-pressure)

---
 rtl/mips_pkg.sv | 14 +
 rtl/wb_fifo.sv | 53 +++++
 rtl/wb_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared register-file widths and the write-back entry type used by the
// arbiter and its deferred-result FIFO.
package mips_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;

    typedef struct packed {
        logic [REG_AW-1:0] wa;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO of deferred slow write-back results.
// Uses pointers and an occupancy count, so DEPTH must be a power of two.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  logic      pop,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    wb_entry_t     mem_q [DEPTH];
    logic          do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges the in-order pipeline result and deferred slow-unit results into the
// single regfile write port; tracks busy registers and throttles on starvation.
module wb_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_wa,
    input  logic [31:0] alu_wd,
    input  logic        slow_valid,
    output logic        slow_ready,
    input  logic [4:0]  slow_wa,
    input  logic [31:0] slow_wd,
    input  logic        issue_valid,
    input  logic [4:0]  issue_wa,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        busy_ra1,
    output logic        busy_ra2,
    output logic        stall_pipe,
    output logic        writeReg,
    output logic [4:0]  wa,
    output logic [31:0] wd
);

    localparam int unsigned SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);

    wb_entry_t   head, slow_in;
    logic        fifo_full, fifo_empty;
    logic        alu_req, xfer, pop, bypass, push;
    logic        commit;
    logic [4:0]  commit_wa;

    logic        we_q, we_d;
    logic [4:0]  wa_q, wa_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] busy_q, busy_d;
    logic [SW-1:0] starve_q, starve_d;
    logic        stall_q, stall_d;

    assign slow_in = '{wa: slow_wa, wd: slow_wd};
    assign alu_req = alu_valid && (alu_wa != REG_ZERO);
    assign xfer    = slow_valid && slow_ready;
    assign pop     = !alu_req && !fifo_empty;
    assign bypass  = !alu_req && fifo_empty && xfer;
    assign push    = xfer && !bypass;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (slow_in),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Write-port mux: pipeline, then FIFO head, then bypassed slow result.
    always_comb begin
        we_d      = 1'b0;
        wa_d      = wa_q;
        wd_d      = wd_q;
        commit    = 1'b0;
        commit_wa = REG_ZERO;
        if (alu_req) begin
            we_d = 1'b1;
            wa_d = alu_wa;
            wd_d = alu_wd;
        end else if (pop) begin
            we_d      = (head.wa != REG_ZERO);
            wa_d      = head.wa;
            wd_d      = head.wd;
            commit    = 1'b1;
            commit_wa = head.wa;
        end else if (bypass) begin
            we_d      = (slow_wa != REG_ZERO);
            wa_d      = slow_wa;
            wd_d      = slow_wd;
            commit    = 1'b1;
            commit_wa = slow_wa;
        end
    end

    // Clear before set so an issue to the committing register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (commit) busy_d[commit_wa] = 1'b0;
        if (issue_valid && (issue_wa != REG_ZERO)) busy_d[issue_wa] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_comb begin
        starve_d = starve_q;
        stall_d  = 1'b0;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q == STARVE_LAST) begin
            stall_d  = 1'b1;
            starve_d = '0;
        end else begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q     <= 1'b0;
            wa_q     <= '0;
            wd_q     <= '0;
            busy_q   <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            we_q     <= we_d;
            wa_q     <= wa_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    assign slow_ready = !fifo_full;
    assign busy_ra1   = busy_q[ra1];
    assign busy_ra2   = busy_q[ra2];
    assign stall_pipe = stall_q;
    assign writeReg   = we_q;
    assign wa         = wa_q;
    assign wd         = wd_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: expected regfile writes go into a queue and a
// negedge monitor checks every write the DUT issues against it.
module tb_wb_arbiter;
    import mips_pkg::*;

    logic        clk, rst;
    logic        alu_valid, slow_valid, issue_valid;
    logic [4:0]  alu_wa, slow_wa, issue_wa, ra1, ra2;
    logic [31:0] alu_wd, slow_wd;
    logic        slow_ready, busy_ra1, busy_ra2, stall_pipe, writeReg;
    logic [4:0]  wa;
    logic [31:0] wd;

    int n_checks = 0;
    int n_fail   = 0;
    wb_entry_t exp_q[$];

    // ra2 follows alu_wa so the bench can flag pipeline writes to busy registers.
    assign ra2 = alu_wa;

    wb_arbiter #(
        .DEPTH      (4),
        .STARVE_MAX (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .alu_valid   (alu_valid),
        .alu_wa      (alu_wa),
        .alu_wd      (alu_wd),
        .slow_valid  (slow_valid),
        .slow_ready  (slow_ready),
        .slow_wa     (slow_wa),
        .slow_wd     (slow_wd),
        .issue_valid (issue_valid),
        .issue_wa    (issue_wa),
        .ra1         (ra1),
        .ra2         (ra2),
        .busy_ra1    (busy_ra1),
        .busy_ra2    (busy_ra2),
        .stall_pipe  (stall_pipe),
        .writeReg    (writeReg),
        .wa          (wa),
        .wd          (wd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{wa: a, wd: d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid   = 1'b0;
        slow_valid  = 1'b0;
        issue_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] a, input logic [31:0] d);
        alu_valid = 1'b1;
        alu_wa    = a;
        alu_wd    = d;
    endtask

    task automatic slow(input logic [4:0] a, input logic [31:0] d);
        slow_valid = 1'b1;
        slow_wa    = a;
        slow_wd    = d;
    endtask

    task automatic issue(input logic [4:0] a);
        issue_valid = 1'b1;
        issue_wa    = a;
    endtask

    // Scoreboard monitor: every issued write must match the queue head.
    always @(negedge clk) begin
        if (writeReg) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got r%0d=%0h, expected no write", wa, wd);
            end else begin
                wb_entry_t e;
                e = exp_q.pop_front();
                if (wa !== e.wa || wd !== e.wd) begin
                    n_fail++;
                    $display("FAIL write_data: got r%0d=%0h, expected r%0d=%0h",
                             wa, wd, e.wa, e.wd);
                end
            end
        end
        if (rst) begin
            assert (!(alu_valid && alu_wa != 5'd0 && busy_ra2))
                else $error("FAIL protocol: pipeline write to busy r%0d", alu_wa);
            assert (!(stall_pipe && alu_valid))
                else $error("FAIL protocol: alu_valid during stall_pipe");
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with every input active.
        rst = 1'b0;
        alu(5'd3, 32'h1); slow(5'd4, 32'h2); issue(5'd9);
        ra1 = 5'd9;
        repeat (3) tick();
        chk("reset_writeReg", 32'(writeReg), 32'd0);
        chk("reset_wa", 32'(wa), 32'd0);
        chk("reset_wd", wd, 32'd0);
        chk("reset_slow_ready", 32'(slow_ready), 32'd1);
        chk("reset_busy", 32'(busy_ra1), 32'd0);
        chk("reset_stall", 32'(stall_pipe), 32'd0);
        idle();
        alu_wa = 5'd0;
        rst = 1'b1;

        // Bypass: issue r5, then its slow result arrives with the FIFO empty.
        ra1 = 5'd5;
        issue(5'd5);
        tick(); idle();
        chk("busy_after_issue", 32'(busy_ra1), 32'd1);
        slow(5'd5, 32'hDEAD_BEEF);
        expect_wr(5'd5, 32'hDEAD_BEEF);
        tick(); idle();
        chk("bypass_latency", 32'(writeReg), 32'd1);
        chk("bypass_busy_clear", 32'(busy_ra1), 32'd0);

        // Priority: pipeline first, slow result the cycle after.
        alu(5'd3, 32'h11); slow(5'd7, 32'h22);
        expect_wr(5'd3, 32'h11);
        expect_wr(5'd7, 32'h22);
        tick(); idle();
        chk("prio_first", 32'(wa), 32'd3);
        tick();
        chk("prio_second", 32'(wa), 32'd7);
        tick();
        chk("prio_idle", 32'(writeReg), 32'd0);

        // $0 handling: bypassed r0 produces no write.
        slow(5'd0, 32'hFFFF);
        tick(); idle();
        chk("zero_bypass", 32'(writeReg), 32'd0);
        // alu to r0 lets the FIFO head through.
        alu(5'd4, 32'h44); slow(5'd6, 32'h66);
        expect_wr(5'd4, 32'h44);
        expect_wr(5'd6, 32'h66);
        tick(); idle();
        alu(5'd0, 32'h99);
        tick(); idle();
        chk("zero_alu_pop", 32'(wa), 32'd6);
        // r0 entry deferred in the FIFO is popped without a write.
        alu(5'd8, 32'h88); slow(5'd0, 32'h123);
        expect_wr(5'd8, 32'h88);
        tick(); idle();
        tick();
        chk("zero_fifo_pop", 32'(writeReg), 32'd0);

        // Scoreboard: set wins over a same-cycle commit.
        ra1 = 5'd9;
        issue(5'd9);
        tick(); idle();
        chk("sb_set", 32'(busy_ra1), 32'd1);
        issue(5'd9); slow(5'd9, 32'h99);
        expect_wr(5'd9, 32'h99);
        tick(); idle();
        chk("sb_set_wins", 32'(busy_ra1), 32'd1);
        slow(5'd9, 32'h9A);
        expect_wr(5'd9, 32'h9A);
        tick(); idle();
        chk("sb_clear", 32'(busy_ra1), 32'd0);
        ra1 = 5'd0;
        issue(5'd0);
        tick(); idle();
        chk("sb_r0", 32'(busy_ra1), 32'd0);

        // Full + starvation: pipeline wins 9 cycles, 4 slow results pile up.
        for (int k = 0; k < 9; k++) begin
            alu(5'(10 + k), 32'h1000 + 32'(k));
            expect_wr(5'(10 + k), 32'h1000 + 32'(k));
            if (k < 4) begin
                chk("full_ready_before", 32'(slow_ready), 32'd1);
                slow(5'(20 + k), 32'h200 + 32'(k));
            end else begin
                slow_valid = 1'b0;
            end
            tick();
            if (k == 3) chk("full_not_ready", 32'(slow_ready), 32'd0);
            if (k == 7) chk("starve_not_yet", 32'(stall_pipe), 32'd0);
            if (k == 8) chk("starve_stall", 32'(stall_pipe), 32'd1);
        end
        idle();
        expect_wr(5'd20, 32'h200);
        tick();
        chk("starve_pop", 32'(wa), 32'd20);
        chk("starve_stall_drop", 32'(stall_pipe), 32'd0);
        chk("full_ready_after", 32'(slow_ready), 32'd1);
        expect_wr(5'd21, 32'h201);
        expect_wr(5'd22, 32'h202);
        expect_wr(5'd23, 32'h203);
        repeat (4) tick();

        // Reset mid-operation drops the FIFO entry and busy bits.
        ra1 = 5'd12;
        alu(5'd13, 32'h13); slow(5'd14, 32'h14); issue(5'd12);
        expect_wr(5'd13, 32'h13);
        tick(); idle();
        chk("midrst_busy_before", 32'(busy_ra1), 32'd1);
        #6;
        rst = 1'b0;
        #1;
        chk("midrst_writeReg", 32'(writeReg), 32'd0);
        chk("midrst_busy", 32'(busy_ra1), 32'd0);
        chk("midrst_ready", 32'(slow_ready), 32'd1);
        rst = 1'b1;
        repeat (4) tick();

        chk("drain", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
